// File: rtl/opp_m_if.sv
//------------------------------------------------------------------------------
// opp_m_if : row in/out bundle for the opp_m matrix negation unit
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface opp_m_if;
   logic        in_valid;
   logic [39:0] m_1;
   logic        out_valid;
   logic [39:0] m_out;
   logic [4:0]  ovf;

   modport master (
      output in_valid,
      output m_1,
      input  out_valid,
      input  m_out,
      input  ovf
   );

   modport slave (
      input  in_valid,
      input  m_1,
      output out_valid,
      output m_out,
      output ovf
   );
endinterface

`default_nettype wire

// File: rtl/opp_m.sv
//------------------------------------------------------------------------------
// opp_m : registered five-lane signed 8-bit row negation, one row per cycle.
//         OPP_M_SATURATE_EN maps -128 to +127 instead of wrapping.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module opp_m (
   input  wire logic clk,
   input  wire logic rst,
   opp_m_if.slave    bus
);

   localparam int          c_lanes = 5;
   localparam logic [7:0]  c_min   = 8'h80;
`ifdef OPP_M_SATURATE_EN
   localparam logic [7:0]  c_max   = 8'h7F;
`endif

   logic [39:0] w_neg;
   logic [4:0]  w_ovf;

   logic        r_valid;
   logic [39:0] r_out;
   logic [4:0]  r_ovf;

   // Each lane negates in isolation so no carry crosses a lane boundary.
   for (genvar i = 0; i < c_lanes; i++) begin : g_lane
      logic [7:0] w_x;
      assign w_x      = bus.m_1[8*i +: 8];
      assign w_ovf[i] = (w_x == c_min);
`ifdef OPP_M_SATURATE_EN
      assign w_neg[8*i +: 8] = w_ovf[i] ? c_max : (~w_x + 8'd1);
`else
      assign w_neg[8*i +: 8] = ~w_x + 8'd1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_out   <= 40'h0;
         r_ovf   <= 5'b0;
      end else if (bus.in_valid) begin
         r_valid <= 1'b1;
         r_out   <= w_neg;
         r_ovf   <= w_ovf;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign bus.out_valid = r_valid;
   assign bus.m_out     = r_out;
   assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_opp_m.sv
//------------------------------------------------------------------------------
// tb_opp_m : directed self-checking bench for opp_m (both OPP_M_SATURATE_EN builds)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_opp_m;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

`ifdef OPP_M_SATURATE_EN
   localparam logic [7:0] c_neg_min = 8'h7F;
`else
   localparam logic [7:0] c_neg_min = 8'h80;
`endif

   opp_m_if bus ();

   opp_m dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [39:0] observed,
                        input logic [39:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Present a row before the next rising edge, then sample just after it.
   task automatic step(input logic valid, input logic [39:0] row);
      @(negedge clk);
      bus.in_valid = valid;
      bus.m_1      = row;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic valid,
                            input logic [39:0] row, input logic [4:0] flags);
      check({tag, ".valid"}, {39'h0, bus.out_valid}, {39'h0, valid});
      check({tag, ".m_out"}, bus.m_out, row);
      check({tag, ".ovf"},   {35'h0, bus.ovf}, {35'h0, flags});
   endtask

   initial begin
      logic [31:0] rnd_lo;
      logic [31:0] rnd_hi;
      logic [39:0] w_row;
      n_checks = 0;
      n_errors = 0;

      rnd_lo = $urandom;
      rnd_hi = $urandom;
      w_row  = {rnd_hi[7:0], rnd_lo};
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.m_1      = w_row;
      #1;
      check_out("reset_t0", 1'b0, 40'h0, 5'b0);
      @(posedge clk);
      #1;
      check_out("reset_edge", 1'b0, 40'h0, 5'b0);
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_out("post_release", 1'b0, 40'h0, 5'b0);

      step(1'b1, 40'h01_02_03_04_05);
      check_out("positive", 1'b1, 40'hFF_FE_FD_FC_FB, 5'b00000);

      step(1'b1, 40'hFF_80_F6_00_7F);
      check_out("mixed", 1'b1, {8'h01, c_neg_min, 8'h0A, 8'h00, 8'h81}, 5'b01000);

      step(1'b1, 40'h0A_0A_0A_0A_0A);
      check_out("hold_load", 1'b1, 40'hF6_F6_F6_F6_F6, 5'b00000);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 40'h55_55_55_55_55);
         check_out("hold_idle", 1'b0, 40'hF6_F6_F6_F6_F6, 5'b00000);
      end

      step(1'b1, 40'h01_01_01_01_01);
      check_out("stream0", 1'b1, 40'hFF_FF_FF_FF_FF, 5'b00000);
      step(1'b1, 40'h02_02_02_02_02);
      check_out("stream1", 1'b1, 40'hFE_FE_FE_FE_FE, 5'b00000);
      step(1'b1, 40'h80_80_80_80_80);
      check_out("stream2", 1'b1, {5{c_neg_min}}, 5'b11111);
      step(1'b1, 40'h7F_7F_7F_7F_7F);
      check_out("stream3", 1'b1, 40'h81_81_81_81_81, 5'b00000);

      step(1'b1, 40'h03_03_03_03_03);
      check_out("pre_rst", 1'b1, 40'hFD_FD_FD_FD_FD, 5'b00000);
      @(negedge clk);
      bus.m_1 = 40'h04_04_04_04_04;
      #2;
      rst = 1'b1;
      #1;
      check_out("mid_rst_async", 1'b0, 40'h0, 5'b0);
      @(posedge clk);
      #1;
      check_out("mid_rst_held", 1'b0, 40'h0, 5'b0);
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_out("mid_rst_release", 1'b0, 40'h0, 5'b0);

      step(1'b1, 40'h00_01_7F_80_FF);
      check_out("after_rst", 1'b1, {8'h00, 8'hFF, 8'h81, c_neg_min, 8'h01}, 5'b00010);

      step(1'b0, 40'h0);
      check_out("final_idle", 1'b0, {8'h00, 8'hFF, 8'h81, c_neg_min, 8'h01}, 5'b00010);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
